// File: rtl/hgc_vram_arbiter.sv
// Single-port VRAM arbiter for the Hercules adapter: display fetches owned by the
// sequencer strobes, ISA read/write ops slotted into the sequencer's ISA window.
module hgc_vram_arbiter #(
    parameter int unsigned VRAM_AW = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [4:0]         clk_seq,
    input  logic               vram_read,
    input  logic               vram_read_a0,
    input  logic               vram_read_char,
    input  logic               vram_read_att,
    input  logic               isa_op_enable,
    input  logic               grph_mode,
    input  logic               gfx_page,
    input  logic [13:0]        crtc_ma,
    input  logic [4:0]         crtc_ra,
    input  logic               bus_req,
    input  logic               bus_wr,
    input  logic [VRAM_AW-1:0] bus_addr,
    input  logic [7:0]         bus_din,
    output logic [7:0]         bus_dout,
    output logic               bus_ack,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    output logic [31:0]        fetch_q
);

    typedef enum logic [1:0] {
        IDLE,
        OP2,
        OP3,
        WAIT_REL
    } state_t;

    state_t       state_q, state_d;
    logic         bus_ack_q, bus_ack_d;
    logic [7:0]   bus_dout_q, bus_dout_d;
    logic         op_wr_q, op_wr_d;
    logic [31:0]  fetch_data_q, fetch_data_d;

    logic               op_start;
    logic [11:0]        gfx_ma;
    logic [VRAM_AW-1:0] disp_addr;
    logic               unused_bits;

    assign unused_bits = ^{crtc_ra[4:2], crtc_ma[13:12]};

    // Second graphics pair (clk_seq >= 16) fetches the next word, wrapping within the page.
    assign gfx_ma = crtc_ma[11:0] + {11'd0, clk_seq[4]};

    always_comb begin
        if (grph_mode) begin
            disp_addr = VRAM_AW'({gfx_page, crtc_ra[1:0], gfx_ma, vram_read_a0});
        end else begin
            disp_addr = VRAM_AW'({crtc_ma[10:0], vram_read_a0});
        end
    end

    // Cutoff at 13 keeps the 3-cycle op clear of the next display fetch.
    assign op_start = (state_q == IDLE) && bus_req && !bus_ack_q && isa_op_enable
                      && (clk_seq <= 5'd13) && !vram_read && reset_n;

    always_comb begin
        state_d      = state_q;
        bus_ack_d    = bus_ack_q;
        bus_dout_d   = bus_dout_q;
        op_wr_d      = op_wr_q;
        fetch_data_d = fetch_data_q;
        vram_addr    = disp_addr;
        vram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_start) begin
                    vram_addr = bus_addr;
                    vram_we   = bus_wr;
                    op_wr_d   = bus_wr;
                    state_d   = OP2;
                end
            end
            OP2: begin
                vram_addr = bus_addr;
                if (!op_wr_q) begin
                    bus_dout_d = vram_rdata;
                end
                bus_ack_d = 1'b1;
                state_d   = OP3;
            end
            OP3: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!bus_req) begin
                    bus_ack_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (vram_read_char) begin
            if (clk_seq[4]) begin
                fetch_data_d[23:16] = vram_rdata;
            end else begin
                fetch_data_d[7:0] = vram_rdata;
            end
        end
        if (vram_read_att) begin
            if (clk_seq[4]) begin
                fetch_data_d[31:24] = vram_rdata;
            end else begin
                fetch_data_d[15:8] = vram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bus_ack_q    <= 1'b0;
            bus_dout_q   <= '0;
            op_wr_q      <= 1'b0;
            fetch_data_q <= '0;
        end else begin
            state_q      <= state_d;
            bus_ack_q    <= bus_ack_d;
            bus_dout_q   <= bus_dout_d;
            op_wr_q      <= op_wr_d;
            fetch_data_q <= fetch_data_d;
        end
    end

    assign bus_ack    = bus_ack_q;
    assign bus_dout   = bus_dout_q;
    assign vram_wdata = bus_din;
    assign fetch_q    = fetch_data_q;

endmodule

// File: tb/tb_hgc_vram_arbiter.sv
// Directed bench for hgc_vram_arbiter: models the char-clock sequencer and a
// synchronous VRAM, then checks fetch capture and ISA op timing against fixed values.
module tb_hgc_vram_arbiter;

    logic        clk;
    logic        reset_n;
    logic [4:0]  clk_seq;
    logic        vram_read, vram_read_a0, vram_read_char, vram_read_att;
    logic        isa_op_enable, grph_mode, gfx_page;
    logic [13:0] crtc_ma;
    logic [4:0]  crtc_ra;
    logic        bus_req, bus_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din, bus_dout;
    logic        bus_ack;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata, vram_rdata;
    logic [31:0] fetch_q;

    logic [7:0]  mem [0:65535];
    logic        want_gfx;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          viol    = 0;
    int          we_count = 0;

    hgc_vram_arbiter #(.VRAM_AW(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk_seq        (clk_seq),
        .vram_read      (vram_read),
        .vram_read_a0   (vram_read_a0),
        .vram_read_char (vram_read_char),
        .vram_read_att  (vram_read_att),
        .isa_op_enable  (isa_op_enable),
        .grph_mode      (grph_mode),
        .gfx_page       (gfx_page),
        .crtc_ma        (crtc_ma),
        .crtc_ra        (crtc_ra),
        .bus_req        (bus_req),
        .bus_wr         (bus_wr),
        .bus_addr       (bus_addr),
        .bus_din        (bus_din),
        .bus_dout       (bus_dout),
        .bus_ack        (bus_ack),
        .vram_addr      (vram_addr),
        .vram_we        (vram_we),
        .vram_wdata     (vram_wdata),
        .vram_rdata     (vram_rdata),
        .fetch_q        (fetch_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        vram_rdata <= mem[vram_addr];
        if (vram_we) mem[vram_addr] = vram_wdata;
    end

    // Sequencer: text period 18, graphics period 32; mode only switches at phase 0.
    initial begin
        int unsigned cnt;
        cnt = 0;
        grph_mode = 1'b0;
        clk_seq = '0;
        vram_read = 1'b0; vram_read_a0 = 1'b0; vram_read_char = 1'b0; vram_read_att = 1'b0;
        isa_op_enable = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt == 0) grph_mode = want_gfx;
            clk_seq = 5'(cnt);
            isa_op_enable = (cnt >= 6) && (cnt <= 15);
            if (grph_mode) begin
                vram_read      = (cnt == 1) || (cnt == 2) || (cnt == 17) || (cnt == 18);
                vram_read_a0   = (cnt == 2) || (cnt == 18);
                vram_read_char = (cnt == 2) || (cnt == 18);
                vram_read_att  = (cnt == 3) || (cnt == 19);
            end else begin
                vram_read      = (cnt == 2) || (cnt == 3);
                vram_read_a0   = (cnt == 3);
                vram_read_char = (cnt == 3);
                vram_read_att  = (cnt == 4);
            end
            cnt = (cnt + 1) % (grph_mode ? 32 : 18);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (vram_read && vram_we) viol++;
            if (vram_we) we_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_seq(input int unsigned n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            #1;
            if (clk_seq == 5'(n)) found = 1'b1;
        end
        if (!found) check("wait_seq", 32'(found), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        bus_req = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_din = '0;
        want_gfx = 1'b0; gfx_page = 1'b0; crtc_ma = 14'h123; crtc_ra = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0246] = 8'h41; mem[16'h0247] = 8'h07;
        mem[16'hDFFE] = 8'h11; mem[16'hDFFF] = 8'h22;
        mem[16'hC000] = 8'h33; mem[16'hC001] = 8'h44;
        mem[16'h2345] = 8'hC3; mem[16'h5000] = 8'h66;

        // Reset state, and no write enable while held in reset
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_dout", 32'(bus_dout), 32'd0);
        check("rst_fetch", fetch_q, 32'd0);
        bus_req = 1'b1; bus_wr = 1'b1; bus_addr = 16'h1111; bus_din = 8'hEE;
        wait_seq(8);
        check("rst_we", 32'(vram_we), 32'd0);
        bus_req = 1'b0; bus_wr = 1'b0;
        wait_seq(16);
        reset_n = 1'b1;

        // 1: text fetch
        wait_seq(2);
        check("t1_addr_char", 32'(vram_addr), 32'h0246);
        check("t1_we", 32'(vram_we), 32'd0);
        wait_seq(3);
        check("t1_addr_att", 32'(vram_addr), 32'h0247);
        wait_seq(5);
        check("t1_fetch", 32'(fetch_q[15:0]), 32'h0741);

        // 2: graphics fetch with MA wrap
        want_gfx = 1'b1; crtc_ma = 14'h0FFF; crtc_ra = 5'd2; gfx_page = 1'b1;
        wait_seq(0);
        wait_seq(1);
        check("t2_addr1", 32'(vram_addr), 32'hDFFE);
        wait_seq(2);
        check("t2_addr2", 32'(vram_addr), 32'hDFFF);
        wait_seq(4);
        check("t2_fetch_lo", 32'(fetch_q[15:0]), 32'h2211);
        wait_seq(17);
        check("t2_addr17", 32'(vram_addr), 32'hC000);
        check("t2_we17", 32'(vram_we), 32'd0);
        wait_seq(18);
        check("t2_addr18", 32'(vram_addr), 32'hC001);
        wait_seq(20);
        check("t2_fetch", fetch_q, 32'h44332211);

        // Back to text: b2/b3 keep their graphics values
        want_gfx = 1'b0; crtc_ma = 14'h123; crtc_ra = '0; gfx_page = 1'b0;
        wait_seq(0);
        wait_seq(5);
        check("text_b23_hold", fetch_q, 32'h44330741);

        // 3: write raised at clk_seq 2
        wait_seq(2);
        bus_req = 1'b1; bus_wr = 1'b1; bus_addr = 16'h1000; bus_din = 8'h5A;
        wait_seq(6);
        check("t3_we_op1", 32'(vram_we), 32'd1);
        check("t3_addr_op1", 32'(vram_addr), 32'h1000);
        wait_seq(7);
        check("t3_we_op2", 32'(vram_we), 32'd0);
        check("t3_addr_op2", 32'(vram_addr), 32'h1000);
        check("t3_ack_op2", 32'(bus_ack), 32'd0);
        wait_seq(8);
        check("t3_ack_op3", 32'(bus_ack), 32'd1);
        check("t3_ram", 32'(mem[16'h1000]), 32'h5A);
        bus_req = 1'b0;
        wait_seq(9);
        check("t3_ack_hold", 32'(bus_ack), 32'd1);
        wait_seq(10);
        check("t3_ack_rel", 32'(bus_ack), 32'd0);
        check("t3_dout_keep", 32'(bus_dout), 32'd0);

        // 4: read raised past the cutoff waits for the next window
        wait_seq(14);
        bus_req = 1'b1; bus_wr = 1'b0; bus_addr = 16'h2345;
        wait_seq(17);
        check("t4_no_late_op", 32'(bus_ack), 32'd0);
        wait_seq(6);
        check("t4_addr_op1", 32'(vram_addr), 32'h2345);
        check("t4_we_op1", 32'(vram_we), 32'd0);
        wait_seq(7);
        check("t4_ack_op2", 32'(bus_ack), 32'd0);
        wait_seq(8);
        check("t4_ack", 32'(bus_ack), 32'd1);
        check("t4_dout", 32'(bus_dout), 32'hC3);
        wait_seq(12);
        check("t4_ack_held", 32'(bus_ack), 32'd1);
        bus_req = 1'b0;
        wait_seq(14);
        check("t4_ack_rel", 32'(bus_ack), 32'd0);
        check("t4_dout_hold", 32'(bus_dout), 32'hC3);

        // 5: request held after ack must not start a second op
        wait_seq(0);
        we_count = 0;
        bus_req = 1'b1; bus_wr = 1'b1; bus_addr = 16'h3000; bus_din = 8'h77;
        wait_seq(8);
        check("t5_ack1", 32'(bus_ack), 32'd1);
        wait_seq(0);
        wait_seq(10);
        check("t5_ack_held", 32'(bus_ack), 32'd1);
        check("t5_one_op", 32'(we_count), 32'd1);
        bus_req = 1'b0;
        wait_seq(11);
        check("t5_ack_low", 32'(bus_ack), 32'd0);
        bus_req = 1'b1; bus_addr = 16'h3001; bus_din = 8'h88;
        #1;
        check("t5_we2", 32'(vram_we), 32'd1);
        check("t5_addr2", 32'(vram_addr), 32'h3001);
        wait_seq(13);
        check("t5_ack2", 32'(bus_ack), 32'd1);
        bus_req = 1'b0;
        wait_seq(15);
        check("t5_ram0", 32'(mem[16'h3000]), 32'h77);
        check("t5_ram1", 32'(mem[16'h3001]), 32'h88);
        check("t5_two_ops", 32'(we_count), 32'd2);

        // 6: reset during OP2 aborts, pending read restarts in the next window
        wait_seq(0);
        bus_req = 1'b1; bus_wr = 1'b0; bus_addr = 16'h5000;
        wait_seq(7);
        reset_n = 1'b0;
        #1;
        check("t6_ack", 32'(bus_ack), 32'd0);
        check("t6_we", 32'(vram_we), 32'd0);
        check("t6_dout", 32'(bus_dout), 32'd0);
        check("t6_fetch", fetch_q, 32'd0);
        wait_seq(16);
        reset_n = 1'b1;
        wait_seq(5);
        check("t6_no_early", 32'(bus_ack), 32'd0);
        wait_seq(6);
        check("t6_addr_restart", 32'(vram_addr), 32'h5000);
        wait_seq(8);
        check("t6_ack_restart", 32'(bus_ack), 32'd1);
        check("t6_dout_restart", 32'(bus_dout), 32'h66);
        bus_req = 1'b0;
        wait_seq(10);
        check("t6_ack_rel", 32'(bus_ack), 32'd0);

        check("no_we_on_fetch", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
